// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared constants, FSM state type and fixed-point helper for the Maxnet engine
package maxnet_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC = 16;
  localparam logic signed [WIDTH-1:0] EPS_DEFAULT = 32'sh0000_3333;
  localparam int MAX_ITER_DEFAULT = 64;
  localparam int N = 4;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  // Full-precision product, then floor division by 2^FRAC through the arithmetic shift.
  function automatic logic signed [2*WIDTH+1:0] mul_shift(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH+1:0] b
  );
    logic signed [2*WIDTH+1:0] prod;
    prod = (2*WIDTH+2)'(a) * (2*WIDTH+2)'(b);
    return prod >>> FRAC;
  endfunction

endpackage

// File: rtl/maxnet_if.sv
// rtl/maxnet_if.sv - start/operand/result bundle between the controller and the Maxnet engine
interface maxnet_if import maxnet_pkg::*; #(
  parameter int MAX_ITER = MAX_ITER_DEFAULT
);
  localparam int CW = $clog2(MAX_ITER + 1);

  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             busy;
  logic             done;
  logic [1:0]       winner;
  logic [WIDTH-1:0] winner_val;
  logic             no_winner;
  logic             timeout;
  logic [CW-1:0]    iter_count;

  modport master (
    output start, in0, in1, in2, in3,
    input  busy, done, winner, winner_val, no_winner, timeout, iter_count
  );

  modport slave (
    input  start, in0, in1, in2, in3,
    output busy, done, winner, winner_val, no_winner, timeout, iter_count
  );

endinterface

// File: rtl/maxnet_neuron.sv
// rtl/maxnet_neuron.sv - combinational lateral-inhibition update for one neuron
module maxnet_neuron import maxnet_pkg::*; #(
  parameter logic signed [WIDTH-1:0] EPS = EPS_DEFAULT
) (
  input  logic [WIDTH-1:0]        x,
  input  logic signed [WIDTH+1:0] s,
  output logic [WIDTH-1:0]        x_next
);

  logic signed [WIDTH+1:0]   o;
  logic signed [2*WIDTH+1:0] p;
  logic signed [2*WIDTH+1:0] d;

  // x is never negative, so d <= x and the low WIDTH bits hold any positive result.
  always_comb begin
    o      = s - $signed({2'b00, x});
    p      = mul_shift(EPS, o);
    d      = $signed({{(WIDTH+2){1'b0}}, x}) - p;
    x_next = (d[2*WIDTH+1] || (d == '0)) ? '0 : d[WIDTH-1:0];
  end

endmodule

// File: rtl/maxnet_engine.sv
// rtl/maxnet_engine.sv - iterative 4-neuron Maxnet winner-take-all engine
module maxnet_engine import maxnet_pkg::*; #(
  parameter logic signed [WIDTH-1:0] EPS = EPS_DEFAULT,
  parameter int MAX_ITER = MAX_ITER_DEFAULT
) (
  input logic clk,
  input logic rst,
  maxnet_if.slave bus
);

  localparam int CW = $clog2(MAX_ITER + 1);

  state_t                  state;
  logic [WIDTH-1:0]        x      [N];
  logic [WIDTH-1:0]        x_next [N];
  logic [WIDTH-1:0]        in_w   [N];
  logic signed [WIDTH+1:0] sum;
  logic [2:0]              nz;
  logic [1:0]              top_idx;
  logic [CW-1:0]           iter_count;
  logic                    busy;
  logic                    done;
  logic                    no_winner;
  logic                    timeout;
  logic [1:0]              winner;
  logic [WIDTH-1:0]        winner_val;

  assign in_w[0] = bus.in0;
  assign in_w[1] = bus.in1;
  assign in_w[2] = bus.in2;
  assign in_w[3] = bus.in3;

  // Largest neuron with lowest-index tie break; when nz<=1 this is also the sole survivor (or 0).
  always_comb begin
    sum     = '0;
    nz      = '0;
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + $signed({2'b00, x[i]});
      nz  = nz + {2'b00, (x[i] != '0)};
      if (x[i] > x[top_idx]) top_idx = 2'(i);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_neuron
    maxnet_neuron #(.EPS(EPS)) u_neuron (
      .x      (x[g]),
      .s      (sum),
      .x_next (x_next[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      for (int i = 0; i < N; i++) x[i] <= '0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      no_winner  <= 1'b0;
      timeout    <= 1'b0;
      winner     <= '0;
      winner_val <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            for (int i = 0; i < N; i++) x[i] <= in_w[i][WIDTH-1] ? '0 : in_w[i];
            iter_count <= '0;
            timeout    <= 1'b0;
            no_winner  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= ITER;
          end
        end
        ITER: begin
          if ((nz <= 3'd1) || (iter_count == CW'(MAX_ITER))) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            winner     <= top_idx;
            winner_val <= x[top_idx];
            no_winner  <= (nz == 3'd0);
            timeout    <= (nz > 3'd1);
          end else begin
            for (int i = 0; i < N; i++) x[i] <= x_next[i];
            iter_count <= iter_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.winner     = winner;
  assign bus.winner_val = winner_val;
  assign bus.no_winner  = no_winner;
  assign bus.timeout    = timeout;
  assign bus.iter_count = iter_count;

endmodule

// File: tb/tb_maxnet_engine.sv
// tb/tb_maxnet_engine.sv - directed scoreboard bench for maxnet_engine
module tb_maxnet_engine;
  import maxnet_pkg::*;

  localparam longint EPS_M = 64'sd13107;

  typedef struct packed {
    logic [1:0]  winner;
    logic [31:0] val;
    logic        no_winner;
    logic        timeout;
    logic [31:0] iter;
  } res_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [31:0] val;
    logic        no_winner;
    logic        timeout;
    logic [6:0]  iter;
  } obs_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  res_t sb[$];

  maxnet_if #(.MAX_ITER(64)) bus ();
  maxnet_if #(.MAX_ITER(2))  bus2 ();

  maxnet_engine #(.MAX_ITER(64)) dut  (.clk(clk), .rst(rst), .bus(bus));
  maxnet_engine #(.MAX_ITER(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d,
                                 input int max_iter);
    longint x[4];
    longint xn[4];
    longint s, o, p, dd;
    int nz, w;
    res_t r;
    x[0] = a[31] ? 0 : longint'(a);
    x[1] = b[31] ? 0 : longint'(b);
    x[2] = c[31] ? 0 : longint'(c);
    x[3] = d[31] ? 0 : longint'(d);
    r = '0;
    nz = 0;
    for (int k = 0; k < 1000; k++) begin
      nz = 0;
      s = 0;
      for (int i = 0; i < 4; i++) begin
        if (x[i] != 0) nz++;
        s += x[i];
      end
      if (nz <= 1) break;
      if (int'(r.iter) == max_iter) begin
        r.timeout = 1'b1;
        break;
      end
      for (int i = 0; i < 4; i++) begin
        o = s - x[i];
        p = (o * EPS_M) >>> 16;
        dd = x[i] - p;
        xn[i] = (dd <= 0) ? 0 : dd;
      end
      x = xn;
      r.iter = r.iter + 1;
    end
    w = 0;
    for (int i = 1; i < 4; i++) if (x[i] > x[w]) w = i;
    r.winner = 2'(w);
    r.val = 32'(x[w]);
    r.no_winner = (nz == 0);
    return r;
  endfunction

  function automatic obs_t observe(input bit sel);
    obs_t o;
    if (sel) begin
      o.busy = bus2.busy; o.done = bus2.done; o.winner = bus2.winner;
      o.val = bus2.winner_val; o.no_winner = bus2.no_winner;
      o.timeout = bus2.timeout; o.iter = 7'(bus2.iter_count);
    end else begin
      o.busy = bus.busy; o.done = bus.done; o.winner = bus.winner;
      o.val = bus.winner_val; o.no_winner = bus.no_winner;
      o.timeout = bus.timeout; o.iter = 7'(bus.iter_count);
    end
    return o;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    if (sel) begin
      bus2.start = st; bus2.in0 = a; bus2.in1 = b; bus2.in2 = c; bus2.in3 = d;
    end else begin
      bus.start = st; bus.in0 = a; bus.in1 = b; bus.in2 = c; bus.in3 = d;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit sel, input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [31:0] d, input bit poke,
                     output obs_t res, output int lat);
    obs_t o;
    res_t e;
    @(negedge clk);
    drive(sel, 1'b1, a, b, c, d);
    sb.push_back(model(a, b, c, d, sel ? 2 : 64));
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h7FFF_FFFF, 32'h0F0F_0F0F);
    o = observe(sel);
    chk({name, ".busy_after_start"}, o.busy, 1);
    lat = 0;
    while (!o.done && lat < 100) begin
      if (poke && lat == 1) drive(sel, 1'b1, 32'h7FFF_0000, 0, 0, 0);
      @(posedge clk); #1;
      lat++;
      if (poke) drive(sel, 1'b0, 0, 0, 0, 0);
      o = observe(sel);
    end
    e = sb.pop_front();
    chk({name, ".done"}, o.done, 1);
    chk({name, ".busy"}, o.busy, 0);
    chk({name, ".latency"}, lat, e.iter + 1);
    chk({name, ".iter_count"}, o.iter, e.iter);
    chk({name, ".winner"}, o.winner, e.winner);
    chk({name, ".winner_val"}, o.val, e.val);
    chk({name, ".no_winner"}, o.no_winner, e.no_winner);
    chk({name, ".timeout"}, o.timeout, e.timeout);
    res = o;
  endtask

  initial begin
    obs_t r, first;
    int lat;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    #2;
    r = observe(1'b0);
    chk("reset.outputs", 64'(r), 64'(obs_t'(0)));
    repeat (2) @(posedge clk);
    #1;
    r = observe(1'b1);
    chk("reset.outputs_dut2", 64'(r), 64'(obs_t'(0)));
    @(negedge clk);
    rst = 1'b0;

    // main vector, with a start pulse mid-run that must be ignored
    run(1'b0, "vecA", 32'h10000, 32'h8000, 32'h4000, 32'hC000, 1'b1, first, lat);
    chk("vecA.latency_const", lat, 6);
    chk("vecA.iter_const", first.iter, 5);
    chk("vecA.winner_const", first.winner, 0);

    run(1'b0, "single", 32'h0, 32'h20000, 32'h0, 32'h0, 1'b0, r, lat);
    chk("single.latency_const", lat, 1);
    chk("single.val_const", r.val, 32'h20000);
    repeat (3) @(posedge clk);
    #1;
    r = observe(1'b0);
    chk("single.done_held", r.done, 1);
    chk("single.winner_held", r.winner, 1);

    run(1'b0, "tie", 32'h10000, 32'h10000, 32'h0, 32'h0, 1'b0, r, lat);
    run(1'b0, "allzero", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, r, lat);
    chk("allzero.no_winner_const", r.no_winner, 1);

    run(1'b0, "negative", 32'h0, 32'h0, 32'hFFFF_0000, 32'h4000, 1'b0, r, lat);
    chk("negative.winner_const", r.winner, 3);
    chk("negative.iter_const", r.iter, 0);

    run(1'b1, "cap2", 32'h10000, 32'h8000, 32'h4000, 32'hC000, 1'b0, r, lat);
    chk("cap2.timeout_const", r.timeout, 1);
    chk("cap2.iter_const", r.iter, 2);

    // async reset in the middle of a run
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h10000, 32'h8000, 32'h4000, 32'hC000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    r = observe(1'b0);
    chk("midrst.busy_before", r.busy, 1);
    chk("midrst.iter_before", r.iter, 2);
    #2;
    rst = 1'b1;
    #1;
    r = observe(1'b0);
    chk("midrst.outputs", 64'(r), 64'(obs_t'(0)));
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, "rerun", 32'h10000, 32'h8000, 32'h4000, 32'hC000, 1'b0, r, lat);
    chk("rerun.same_as_first", 64'(r), 64'(first));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
